// File: rtl/monitor_link_if.sv
// Bundles the command, LOAD/DUMP data and UART byte-port signals of monitor_link_master.
// The master modport is the initiator's view; the slave modport is the view of its environment.
interface monitor_link_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [5:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting;
    logic        received;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  is_transmitting, received, rx_byte,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output tx_byte, transmit, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output is_transmitting, received, rx_byte,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  tx_byte, transmit, busy, done, err
    );
endinterface

// File: rtl/monitor_link_master.sv
// Host-side initiator for the serial monitor protocol: frames LOAD/DUMP/EXEC commands into UART bytes.
// Define ECHO_CHECK_EN to compare every echo against the sent byte (mismatch -> err=1).
module monitor_link_master #(
    parameter int unsigned TIMEOUT_CYCLES = 36000,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    monitor_link_if.master bus
);

    localparam logic [1:0] OP_BAD  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;
    localparam logic [1:0] OP_EXEC = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ECHO    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BAD_OP  = 2'd3;

    localparam logic [TIMEOUT_W-1:0] TMR_RELOAD = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        HDR_TX,
        HDR_ECHO,
        DATA_REQ,
        DATA_TX,
        DATA_ECHO,
        DUMP_RX,
        FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           addr_q, addr_d;
    logic [1:0]            op_q, op_d;
    logic [5:0]            len_q, len_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic                  pad_q, pad_d;
    logic [7:0]            wr_byte_q, wr_byte_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  transmit_q, transmit_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic [1:0]            err_q, err_d;
    logic [TIMEOUT_W-1:0]  tmr_q, tmr_d;

    logic [7:0]            hdr_byte;
    logic                  echo_bad;

    always_comb begin
        case (hdr_idx_q)
            2'd0:    hdr_byte = addr_q[15:8];
            2'd1:    hdr_byte = addr_q[7:0];
            default: hdr_byte = {op_q, len_q};
        endcase
    end

`ifdef ECHO_CHECK_EN
    assign echo_bad = (bus.rx_byte != tx_byte_q);
`else
    assign echo_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold/idle value first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        len_d      = len_q;
        hdr_idx_d  = hdr_idx_q;
        pad_d      = pad_q;
        wr_byte_d  = wr_byte_q;
        tx_byte_d  = tx_byte_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        transmit_d = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        tmr_d      = (tmr_q != '0) ? tmr_q - TIMEOUT_W'(1) : '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d    = bus.cmd_addr;
                    op_d      = bus.cmd_op;
                    len_d     = (bus.cmd_op == OP_EXEC) ? 6'd0 : bus.cmd_len;
                    hdr_idx_d = 2'd0;
                    pad_d     = 1'b0;
                    err_d     = (bus.cmd_op == OP_BAD) ? ERR_BAD_OP : ERR_OK;
                    state_d   = (bus.cmd_op == OP_BAD) ? FINISH : HDR_TX;
                end
            end
            HDR_TX: begin
                if (!bus.is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = hdr_byte;
                    tmr_d      = TMR_RELOAD;
                    state_d    = HDR_ECHO;
                end
            end
            HDR_ECHO: begin
                // A byte arriving in the expiry cycle still counts as the echo.
                if (bus.received) begin
                    tmr_d = TMR_RELOAD;
                    if (echo_bad) begin
                        err_d   = ERR_ECHO;
                        state_d = FINISH;
                    end else if (hdr_idx_q != 2'd2) begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        state_d   = HDR_TX;
                    end else begin
                        case (op_q)
                            OP_LOAD: begin
                                if (len_q == 6'd0) begin
                                    wr_byte_d = 8'h00;
                                    pad_d     = 1'b1;
                                    state_d   = DATA_TX;
                                end else begin
                                    state_d = DATA_REQ;
                                end
                            end
                            OP_DUMP: state_d = (len_q == 6'd0) ? FINISH : DUMP_RX;
                            default: state_d = FINISH;
                        endcase
                    end
                end else if (tmr_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = FINISH;
                end
            end
            DATA_REQ: begin
                if (bus.wr_valid) begin
                    wr_ready_d = 1'b1;
                    wr_byte_d  = bus.wr_data;
                    state_d    = DATA_TX;
                end
            end
            DATA_TX: begin
                // The zero-length pad byte is never echoed, so the command ends with its pulse.
                if (!bus.is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = wr_byte_q;
                    tmr_d      = TMR_RELOAD;
                    state_d    = pad_q ? FINISH : DATA_ECHO;
                end
            end
            DATA_ECHO: begin
                if (bus.received) begin
                    tmr_d = TMR_RELOAD;
                    if (echo_bad) begin
                        err_d   = ERR_ECHO;
                        state_d = FINISH;
                    end else begin
                        len_d   = len_q - 6'd1;
                        state_d = (len_q == 6'd1) ? FINISH : DATA_REQ;
                    end
                end else if (tmr_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = FINISH;
                end
            end
            DUMP_RX: begin
                if (bus.received) begin
                    tmr_d      = TMR_RELOAD;
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.rx_byte;
                    len_d      = len_q - 6'd1;
                    state_d    = (len_q == 6'd1) ? FINISH : DUMP_RX;
                end else if (tmr_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            op_q       <= '0;
            len_q      <= '0;
            hdr_idx_q  <= '0;
            pad_q      <= 1'b0;
            wr_byte_q  <= '0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= ERR_OK;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            len_q      <= len_d;
            hdr_idx_q  <= hdr_idx_d;
            pad_q      <= pad_d;
            wr_byte_q  <= wr_byte_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FINISH);
    assign bus.err       = err_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.transmit  = transmit_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_monitor_link_master.sv
// Self-checking bench for monitor_link_master: a UART/monitor model echoes bytes and serves DUMP data,
// while scoreboards hold the expected tx and rd byte streams.
module tb_monitor_link_master;

    localparam int T_CYC = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    monitor_link_if bus_if ();

    monitor_link_master #(
        .TIMEOUT_CYCLES(T_CYC),
        .TIMEOUT_W     (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wr_q[$];
    logic [7:0] dump_q[$];

    int echo_left   = 0;
    int corrupt_at  = -1;
    int tx_seen     = 0;
    int done_cnt    = 0;
    int rd_cnt      = 0;
    int wr_pops     = 0;
    int last_rx_cyc = 0;
    int done_cyc    = 0;
    logic [1:0] done_err = 2'd0;

    // Output monitor and LOAD data source.
    initial begin
        bus_if.wr_valid = 1'b0;
        bus_if.wr_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_if.done === 1'b1) begin
                done_cnt++;
                done_err = bus_if.err;
                done_cyc = cyc;
            end
            if (bus_if.rd_valid === 1'b1) begin
                rd_cnt++;
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: rd_data=%02h, no byte expected", bus_if.rd_data);
                end else begin
                    logic [7:0] e;
                    e = exp_rd.pop_front();
                    if (bus_if.rd_data !== e) begin
                        n_fail++;
                        $display("FAIL rd_data: got %02h, expected %02h", bus_if.rd_data, e);
                    end
                end
            end
            if (bus_if.wr_ready === 1'b1) begin
                wr_pops++;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
            bus_if.wr_valid = (wr_q.size() > 0);
            bus_if.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
        end
    end

    // UART + remote monitor model: checks each transmitted byte, echoes it, then streams DUMP bytes.
    initial begin
        bus_if.is_transmitting = 1'b0;
        bus_if.received        = 1'b0;
        bus_if.rx_byte         = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.transmit === 1'b1) begin
                logic [7:0] t;
                t = bus_if.tx_byte;
                tx_seen++;
                n_checks++;
                if (exp_tx.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: tx_byte=%02h, no byte expected", t);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (t !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %02h, expected %02h", t, e);
                    end
                end
                if (echo_left > 0) begin
                    echo_left--;
                    bus_if.is_transmitting = 1'b1;
                    repeat (4) @(negedge clk);
                    bus_if.is_transmitting = 1'b0;
                    repeat (2) @(negedge clk);
                    bus_if.rx_byte  = (tx_seen == corrupt_at) ? (t ^ 8'hFF) : t;
                    bus_if.received = 1'b1;
                    @(negedge clk);
                    bus_if.received = 1'b0;
                    if (echo_left == 0) begin
                        while (dump_q.size() > 0) begin
                            repeat (5) @(negedge clk);
                            bus_if.rx_byte  = dump_q.pop_front();
                            bus_if.received = 1'b1;
                            last_rx_cyc     = cyc;
                            @(negedge clk);
                            bus_if.received = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [5:0] len);
        int guard;
        guard = 0;
        while (bus_if.cmd_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        bus_if.cmd_op    = op;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = len;
        bus_if.cmd_valid = 1'b1;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (done_cnt != start_cnt);
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus_if.cmd_ready, bus_if.busy, bus_if.done, bus_if.transmit,
               bus_if.wr_ready, bus_if.rd_valid, bus_if.err, bus_if.tx_byte};
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %04h, expected 8000", obs);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        obs = {bus_if.cmd_ready, bus_if.busy, bus_if.done, bus_if.transmit,
               bus_if.wr_ready, bus_if.rd_valid, bus_if.err, bus_if.tx_byte};
        n_checks++;
        if (obs !== 16'h8000) begin
            n_fail++;
            $display("FAIL idle_outputs: got %04h, expected 8000", obs);
        end
    endtask

    task automatic test_load();
        int start, pops0;
        bit ok;
        start = done_cnt; pops0 = wr_pops; tx_seen = 0; echo_left = 5;
        exp_tx = '{8'h00, 8'h10, 8'h42, 8'hAA, 8'hBB};
        wr_q   = '{8'hAA, 8'hBB};
        issue(2'd1, 16'h0010, 6'd2);
        wait_done(start, 2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL load_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd0) begin n_fail++; $display("FAIL load_err: got %0d, expected 0", done_err); end
        n_checks++;
        if (exp_tx.size() != 0) begin n_fail++; $display("FAIL load_tx_count: %0d bytes unsent, expected 0", exp_tx.size()); end
        n_checks++;
        if (wr_pops - pops0 != 2) begin n_fail++; $display("FAIL load_wr_ready: got %0d pulses, expected 2", wr_pops - pops0); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt - start != 1) begin n_fail++; $display("FAIL load_done_count: got %0d, expected 1", done_cnt - start); end
    endtask

    task automatic test_dump();
        int start, rd0;
        bit ok;
        start = done_cnt; rd0 = rd_cnt; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h01, 8'h00, 8'h83};
        dump_q = '{8'h11, 8'h22, 8'h33};
        exp_rd = '{8'h11, 8'h22, 8'h33};
        issue(2'd2, 16'h0100, 6'd3);
        wait_done(start, 2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dump_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd0) begin n_fail++; $display("FAIL dump_err: got %0d, expected 0", done_err); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_cnt - rd0 != 3) begin n_fail++; $display("FAIL dump_rd_count: got %0d, expected 3", rd_cnt - rd0); end
        n_checks++;
        if (exp_tx.size() != 0) begin n_fail++; $display("FAIL dump_tx_count: %0d bytes unsent, expected 0", exp_tx.size()); end
    endtask

    task automatic test_exec_and_busy();
        int start, rd0, pops0;
        bit ok;
        start = done_cnt; rd0 = rd_cnt; pops0 = wr_pops; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h00, 8'h00, 8'hC0};
        issue(2'd3, 16'h0000, 6'h15);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_if.busy, bus_if.cmd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL exec_busy: busy/cmd_ready got %b, expected 10", {bus_if.busy, bus_if.cmd_ready});
        end
        bus_if.cmd_op = 2'd1; bus_if.cmd_addr = 16'hBEEF; bus_if.cmd_len = 6'd1;
        bus_if.cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        wait_done(start, 2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL exec_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd0) begin n_fail++; $display("FAIL exec_err: got %0d, expected 0", done_err); end
        repeat (40) @(negedge clk);
        n_checks++;
        if (tx_seen != 3) begin n_fail++; $display("FAIL exec_tx_count: got %0d, expected 3", tx_seen); end
        n_checks++;
        if ((wr_pops - pops0) + (rd_cnt - rd0) != 0) begin
            n_fail++;
            $display("FAIL exec_data_strobes: got %0d wr_ready and %0d rd_valid, expected 0", wr_pops - pops0, rd_cnt - rd0);
        end
        n_checks++;
        if (done_cnt - start != 1) begin n_fail++; $display("FAIL exec_done_count: got %0d, expected 1", done_cnt - start); end
    endtask

    task automatic test_echo_mismatch();
        int start;
        bit ok;
        logic [1:0] exp_err;
`ifdef ECHO_CHECK_EN
        exp_err = 2'd1;
`else
        exp_err = 2'd0;
`endif
        start = done_cnt; tx_seen = 0; echo_left = 4; corrupt_at = 4;
        exp_tx = '{8'h00, 8'h20, 8'h41, 8'hA5};
        wr_q   = '{8'hA5};
        issue(2'd1, 16'h0020, 6'd1);
        wait_done(start, 2000, ok);
        corrupt_at = -1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mismatch_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== exp_err) begin n_fail++; $display("FAIL mismatch_err: got %0d, expected %0d", done_err, exp_err); end
        n_checks++;
        if (exp_tx.size() != 0) begin n_fail++; $display("FAIL mismatch_tx_count: %0d bytes unsent, expected 0", exp_tx.size()); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_dump_timeout();
        int start, rd0, lat;
        bit ok;
        start = done_cnt; rd0 = rd_cnt; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h01, 8'h00, 8'h84};
        dump_q = '{8'h44, 8'h55};
        exp_rd = '{8'h44, 8'h55};
        issue(2'd2, 16'h0100, 6'd4);
        wait_done(start, T_CYC + 500, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd2) begin n_fail++; $display("FAIL timeout_err: got %0d, expected 2", done_err); end
        lat = done_cyc - last_rx_cyc;
        n_checks++;
        if (lat < T_CYC || lat > T_CYC + 3) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", lat, T_CYC, T_CYC + 3);
        end
        n_checks++;
        if (rd_cnt - rd0 != 2) begin n_fail++; $display("FAIL timeout_rd_count: got %0d, expected 2", rd_cnt - rd0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_load_len0();
        int start, pops0;
        bit ok;
        start = done_cnt; pops0 = wr_pops; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h00, 8'h10, 8'h40, 8'h00};
        issue(2'd1, 16'h0010, 6'd0);
        wait_done(start, 2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL len0_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd0) begin n_fail++; $display("FAIL len0_err: got %0d, expected 0", done_err); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (tx_seen != 4) begin n_fail++; $display("FAIL len0_tx_count: got %0d, expected 4", tx_seen); end
        n_checks++;
        if (wr_pops != pops0) begin n_fail++; $display("FAIL len0_wr_ready: got %0d pulses, expected 0", wr_pops - pops0); end
    endtask

    task automatic test_bad_op();
        int start;
        bit ok;
        start = done_cnt; tx_seen = 0; echo_left = 0;
        issue(2'd0, 16'h1234, 6'd5);
        wait_done(start, 50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL badop_done: no done pulse, expected one"); end
        n_checks++;
        if (done_err !== 2'd3) begin n_fail++; $display("FAIL badop_err: got %0d, expected 3", done_err); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (tx_seen != 0) begin n_fail++; $display("FAIL badop_tx_count: got %0d, expected 0", tx_seen); end
    endtask

    task automatic test_reset_abort();
        int start, guard;
        bit ok;
        start = done_cnt; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h00, 8'h30, 8'h41, 8'h77};
        wr_q   = '{8'h77};
        issue(2'd1, 16'h0030, 6'd1);
        guard = 0;
        while (tx_seen < 4 && guard < 2000) begin @(negedge clk); guard++; end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b, expected 1", bus_if.busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.busy, bus_if.cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_state: busy/cmd_ready got %b, expected 01", {bus_if.busy, bus_if.cmd_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt != start) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", done_cnt - start); end
        start = done_cnt; tx_seen = 0; echo_left = 3;
        exp_tx = '{8'h00, 8'h00, 8'hC0};
        issue(2'd3, 16'h0000, 6'd0);
        wait_done(start, 2000, ok);
        n_checks++;
        if (!ok || done_err !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_exec: done=%0b err=%0d, expected done=1 err=0", ok, done_err);
        end
        n_checks++;
        if (exp_tx.size() != 0) begin n_fail++; $display("FAIL abort_exec_tx: %0d bytes unsent, expected 0", exp_tx.size()); end
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'd0;
        bus_if.cmd_addr  = 16'h0000;
        bus_if.cmd_len   = 6'd0;
        test_reset();
        test_load();
        test_dump();
        test_exec_and_busy();
        test_echo_mismatch();
        test_dump_timeout();
        test_load_len0();
        test_bad_op();
        test_reset_abort();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
